// File: rtl/diff_sym_demapper_if.sv
// Stream bundle for the demapper: symbol input stream and packed byte output stream.
// slave  = demapper side (consumes symbols, produces bytes)
// master = upstream/downstream side (produces symbols, consumes bytes)
interface diff_sym_demapper_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [3:0]  out_nbits;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_nbits
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_nbits
  );
endinterface

// File: rtl/diff_sym_demapper.sv
// Hard-decision DBPSK/DQPSK demapper and MSB-first bit packer.
// Slices each Q1.15 {I,Q} increment to 1 bit or a Gray dibit and packs bits into
// bytes; TLAST flushes a partial byte. Single-stage output register.
module diff_sym_demapper (
  input  logic                  clk_bb,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clr,
  input  logic [2:0]            mode,
  diff_sym_demapper_if.slave    s,
  output logic [31:0]           sym_cnt
);

  logic [7:0]  r_shreg;
  logic [3:0]  r_bit_cnt;
  logic        r_byte_qpsk;
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        r_out_last;
  logic [3:0]  r_out_nbits;
  logic [31:0] r_sym_cnt;

  logic        w_start;
  logic        w_qpsk;
  logic [3:0]  w_bps;
  logic [3:0]  w_nbits;
  logic        w_completes;
  logic        w_accept;
  logic        w_drain;
  logic [15:0] w_i;
  logic [15:0] w_q;
  logic [16:0] w_i_ext;
  logic [16:0] w_q_ext;
  logic [16:0] w_abs_i;
  logic [16:0] w_abs_q;
  logic [1:0]  w_dibit;
  logic [7:0]  w_sym_bits;
  logic [7:0]  w_base;
  logic [7:0]  w_shreg_next;

  // Bits-per-symbol come from the live mode only at a byte boundary; mid-byte the
  // latched byte mode holds so a mode change never splits a byte.
  assign w_start     = (r_bit_cnt == 4'd0);
  assign w_qpsk      = w_start ? (mode == 3'd1) : r_byte_qpsk;
  assign w_bps       = w_qpsk ? 4'd2 : 4'd1;
  assign w_nbits     = r_bit_cnt + w_bps;
  assign w_completes = (w_nbits >= 4'd8) | s.in_last;

  // Readiness never looks at in_data; only a byte-completing symbol can be blocked.
  assign s.in_ready = rst_n & enable & ~clr & (~w_completes | ~r_out_valid | s.out_ready);
  assign w_accept   = s.in_valid & s.in_ready;
  assign w_drain    = r_out_valid & s.out_ready;

  // 17-bit magnitudes so -32768 becomes +32768 without saturating.
  assign w_i     = s.in_data[31:16];
  assign w_q     = s.in_data[15:0];
  assign w_i_ext = {w_i[15], w_i};
  assign w_q_ext = {w_q[15], w_q};
  assign w_abs_i = w_i[15] ? (17'd0 - w_i_ext) : w_i_ext;
  assign w_abs_q = w_q[15] ? (17'd0 - w_q_ext) : w_q_ext;

  // Slice the symbol into its bits, left-justified so they can be shifted into place.
  always_comb begin
    w_dibit    = 2'b00;
    w_sym_bits = 8'h00;
    if (w_qpsk) begin
      if (w_abs_i >= w_abs_q) w_dibit = w_i[15] ? 2'b11 : 2'b00;
      else                    w_dibit = w_q[15] ? 2'b10 : 2'b01;
      w_sym_bits = {w_dibit, 6'b0};
    end else begin
      w_sym_bits = {w_i[15], 7'b0};
    end
  end

  assign w_base       = w_start ? 8'h00 : r_shreg;
  assign w_shreg_next = w_base | (w_sym_bits >> r_bit_cnt);

  // Packer, output register and symbol counter.
  always_ff @(posedge clk_bb) begin
    if (!rst_n || clr) begin
      r_shreg     <= 8'h00;
      r_bit_cnt   <= 4'd0;
      r_byte_qpsk <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
      r_out_nbits <= 4'd0;
      r_sym_cnt   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_sym_cnt <= r_sym_cnt + 32'd1;
        if (w_start) r_byte_qpsk <= w_qpsk;
        if (w_completes) begin
          r_shreg   <= 8'h00;
          r_bit_cnt <= 4'd0;
        end else begin
          r_shreg   <= w_shreg_next;
          r_bit_cnt <= w_nbits;
        end
      end
      if (w_accept && w_completes) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_shreg_next;
        r_out_last  <= s.in_last;
        r_out_nbits <= w_nbits;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign s.out_valid = r_out_valid;
  assign s.out_data  = r_out_data;
  assign s.out_last  = r_out_last;
  assign s.out_nbits = r_out_nbits;
  assign sym_cnt     = r_sym_cnt;

endmodule

// File: tb/tb_diff_sym_demapper.sv
// Self-checking bench for diff_sym_demapper: symbol vector table with byte
// expectations pushed to a scoreboard, plus backpressure/reset/clear sequences.
module tb_diff_sym_demapper;
  logic        clk_bb = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clr;
  logic [2:0]  mode;
  logic [31:0] sym_cnt;

  diff_sym_demapper_if dut_if ();

  diff_sym_demapper dut (
    .clk_bb  (clk_bb),
    .rst_n   (rst_n),
    .enable  (enable),
    .clr     (clr),
    .mode    (mode),
    .s       (dut_if.slave),
    .sym_cnt (sym_cnt)
  );

  always #5 clk_bb = ~clk_bb;

  typedef struct {
    logic [7:0] data;
    logic [3:0] nbits;
    logic       last;
  } exp_t;

  typedef struct {
    logic [2:0]        m;
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic              last;
    logic              exp_en;
    logic [7:0]        exp_data;
    logic [3:0]        exp_nbits;
    logic              exp_last;
  } vec_t;

  localparam logic signed [15:0] P = 16'sd32767;
  localparam logic signed [15:0] N = -16'sd32767;

  exp_t  sb[$];
  exp_t  mon_e;
  vec_t  vecs[32];
  int    nvec = 0;
  int    checks = 0;
  int    failures = 0;
  int    sym_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] m, input logic signed [15:0] i, input logic signed [15:0] q,
                         input logic last, input logic exp_en, input logic [7:0] ed,
                         input logic [3:0] en, input logic el);
    vecs[nvec] = '{m, i, q, last, exp_en, ed, en, el};
    nvec++;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [3:0] n, input logic l);
    exp_t e;
    e.data = d; e.nbits = n; e.last = l;
    sb.push_back(e);
  endtask

  task automatic send_sym(input logic [2:0] m, input logic signed [15:0] i,
                          input logic signed [15:0] q, input logic last);
    bit acc;
    acc = 1'b0;
    mode = m;
    dut_if.in_valid = 1'b1;
    dut_if.in_data  = {i, q};
    dut_if.in_last  = last;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk_bb);
      if (dut_if.in_ready) acc = 1'b1;
      @(posedge clk_bb);
      #1;
    end
    dut_if.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
    end else begin
      sym_model++;
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      @(posedge clk_bb);
      #1;
    end
  endtask

  // Scoreboard monitor: a byte transfer happens at the next edge when valid&ready here.
  always @(negedge clk_bb) begin
    if (rst_n && !clr && dut_if.out_valid && dut_if.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got byte 0x%0h nbits %0d expected none",
                 dut_if.out_data, dut_if.out_nbits);
      end else begin
        mon_e = sb.pop_front();
        if (dut_if.out_data !== mon_e.data || dut_if.out_nbits !== mon_e.nbits ||
            dut_if.out_last !== mon_e.last) begin
          failures++;
          $display("FAIL sb_byte: got data 0x%0h nbits %0d last %0b expected data 0x%0h nbits %0d last %0b",
                   dut_if.out_data, dut_if.out_nbits, dut_if.out_last,
                   mon_e.data, mon_e.nbits, mon_e.last);
        end
      end
    end
  end

  initial begin
    logic [7:0] b1;
    logic [7:0] b2;

    rst_n = 1'b0; enable = 1'b1; clr = 1'b0; mode = 3'd0;
    dut_if.in_valid = 1'b0; dut_if.in_data = 32'h0; dut_if.in_last = 1'b0;
    dut_if.out_ready = 1'b1;

    // DBPSK full byte -> 0x62
    add_vec(0, P, 0, 0, 0, 0, 0, 0);
    add_vec(0, N, 0, 0, 0, 0, 0, 0);
    add_vec(0, N, 0, 0, 0, 0, 0, 0);
    add_vec(0, P, 0, 0, 0, 0, 0, 0);
    add_vec(0, P, 0, 0, 0, 0, 0, 0);
    add_vec(0, P, 0, 0, 0, 0, 0, 0);
    add_vec(0, N, 0, 0, 0, 0, 0, 0);
    add_vec(0, P, 0, 0, 1, 8'h62, 4'd8, 1'b0);
    // DQPSK full byte -> 0x78, last
    add_vec(1, 0, P, 0, 0, 0, 0, 0);
    add_vec(1, N, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, N, 0, 0, 0, 0, 0);
    add_vec(1, P, 0, 1, 1, 8'h78, 4'd8, 1'b1);
    // Partial flush -> 0xC0, 3 bits
    add_vec(0, N, 0, 0, 0, 0, 0, 0);
    add_vec(0, N, 0, 0, 0, 0, 0, 0);
    add_vec(0, P, 0, 1, 1, 8'hC0, 4'd3, 1'b1);
    // Edge values, each a one-symbol frame starting at bit 7
    add_vec(0, -16'sd32768, 0, 1, 1, 8'h80, 4'd1, 1'b1);
    add_vec(1, 16'sd16384, 16'sd16384, 1, 1, 8'h00, 4'd2, 1'b1);
    add_vec(1, 16'sd16384, -16'sd16385, 1, 1, 8'h80, 4'd2, 1'b1);
    // Mode switch mid-byte: stays 1 bit per symbol -> 101_11111
    add_vec(0, N, 0, 0, 0, 0, 0, 0);
    add_vec(0, P, 0, 0, 0, 0, 0, 0);
    add_vec(0, N, 0, 0, 0, 0, 0, 0);
    add_vec(1, N, 0, 0, 0, 0, 0, 0);
    add_vec(1, N, 0, 0, 0, 0, 0, 0);
    add_vec(1, N, 0, 0, 0, 0, 0, 0);
    add_vec(1, N, 0, 0, 0, 0, 0, 0);
    add_vec(1, N, 0, 0, 1, 8'hBF, 4'd8, 1'b0);

    // Reset state
    repeat (2) @(posedge clk_bb);
    #1;
    chk("rst_out_valid", {31'd0, dut_if.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, dut_if.out_data}, 32'd0);
    chk("rst_out_last", {31'd0, dut_if.out_last}, 32'd0);
    chk("rst_out_nbits", {28'd0, dut_if.out_nbits}, 32'd0);
    chk("rst_sym_cnt", sym_cnt, 32'd0);
    chk("rst_in_ready", {31'd0, dut_if.in_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk_bb);
    #1;

    // Table-driven vectors
    for (int k = 0; k < nvec; k++) begin
      if (vecs[k].exp_en) push_exp(vecs[k].exp_data, vecs[k].exp_nbits, vecs[k].exp_last);
      send_sym(vecs[k].m, vecs[k].i, vecs[k].q, vecs[k].last);
      chk("vec_sym_cnt", sym_cnt, sym_model);
    end
    wait_drain();
    chk("sym_cnt_after_table", sym_cnt, 32'd26);

    // enable low blocks input
    enable = 1'b0;
    dut_if.in_valid = 1'b1;
    #1;
    chk("enable_low_in_ready", {31'd0, dut_if.in_ready}, 32'd0);
    dut_if.in_valid = 1'b0;
    enable = 1'b1;

    // Backpressure: 16 DBPSK symbols with out_ready low
    b1 = 8'hA5;
    b2 = 8'h3C;
    dut_if.out_ready = 1'b0;
    push_exp(b1, 4'd8, 1'b0);
    push_exp(b2, 4'd8, 1'b0);
    for (int k = 0; k < 8; k++) send_sym(0, b1[7-k] ? N : P, 0, 0);
    for (int k = 0; k < 7; k++) send_sym(0, b2[7-k] ? N : P, 0, 0);
    mode = 3'd0;
    dut_if.in_valid = 1'b1;
    dut_if.in_data  = {(b2[0] ? N : P), 16'sd0};
    dut_if.in_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_bb);
      chk("bp_in_ready_sym16", {31'd0, dut_if.in_ready}, 32'd0);
      chk("bp_hold_valid", {31'd0, dut_if.out_valid}, 32'd1);
      chk("bp_hold_data", {24'd0, dut_if.out_data}, {24'd0, b1});
    end
    @(posedge clk_bb);
    #1;
    dut_if.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_recover", {31'd0, dut_if.in_ready}, 32'd1);
    @(negedge clk_bb);
    @(posedge clk_bb);
    #1;
    dut_if.in_valid = 1'b0;
    sym_model++;
    wait_drain();
    chk("bp_sym_cnt", sym_cnt, sym_model);

    // Reset mid-frame discards the partial byte
    send_sym(0, P, 0, 0);
    send_sym(0, N, 0, 0);
    send_sym(0, P, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, dut_if.in_ready}, 32'd0);
    repeat (2) @(posedge clk_bb);
    #1;
    chk("midrst_sym_cnt", sym_cnt, 32'd0);
    rst_n = 1'b1;
    sym_model = 0;
    push_exp(8'h80, 4'd1, 1'b1);
    send_sym(0, N, 0, 1);
    wait_drain();

    // Clear mid-byte
    for (int k = 0; k < 5; k++) send_sym(0, (k % 2) ? N : P, 0, 0);
    clr = 1'b1;
    dut_if.in_valid = 1'b1;
    #1;
    chk("clr_in_ready", {31'd0, dut_if.in_ready}, 32'd0);
    dut_if.in_valid = 1'b0;
    @(posedge clk_bb);
    #1;
    clr = 1'b0;
    chk("clr_sym_cnt", sym_cnt, 32'd0);
    chk("clr_out_valid", {31'd0, dut_if.out_valid}, 32'd0);
    sym_model = 0;
    push_exp(8'hFF, 4'd8, 1'b0);
    for (int k = 0; k < 8; k++) send_sym(0, N, 0, 0);
    chk("clr_sym_cnt_8", sym_cnt, 32'd8);
    wait_drain();

    repeat (3) @(posedge clk_bb);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
